// File: rtl/adc_spi_pkg.sv
// Shared definitions for the multi-channel SPI ADC sampler: FSM encodings and
// constant helpers that derive frame geometry and counter widths from parameters.
// No logic, no latency, no flow control.
package adc_spi_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FRAME = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam logic [1:0] ST_QUIET = 2'd3;

    // SCLK periods per CS_n-low frame
    function automatic int frame_bits(input int lead, input int data_w, input int trail);
        return lead + data_w + trail;
    endfunction

    // iClk cycles per SCLK period
    function automatic int bit_cyc(input int half_div);
        return 2 * half_div;
    endfunction

    // Majority-vote window length per bit; odd whenever half_div is even
    function automatic int votes(input int half_div);
        return half_div - 3;
    endfunction

    // Bits needed to hold values 0..n-1 (at least one bit)
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_bit_voter.sv
// One MISO lane: 2-flop synchroniser, majority-vote counter and MSB-first shift register.
// Latency: vote window sees MISO two iClk cycles late; a decided bit enters the shift register on iDecide.
// No backpressure: strobes come from the frame sequencer and are acted on every cycle.
//
// Ports: iMiso (raw lane), iClr (start of frame), iVote_en (inside vote window),
//        iDecide (last cycle of the bit), iShift_en (bit is a data bit),
//        oShift_d (shift register value after this clock edge).
module spi_bit_voter
    import adc_spi_pkg::*;
#(
    parameter int DATA_W   = 12,
    parameter int HALF_DIV = 10
) (
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic              iMiso,
    input  logic              iClr,
    input  logic              iVote_en,
    input  logic              iDecide,
    input  logic              iShift_en,
    output logic [DATA_W-1:0] oShift_d
);

    localparam int W     = votes(HALF_DIV);
    localparam int CNT_W = cnt_w(W + 1);
    localparam logic [CNT_W-1:0] THRESH = CNT_W'((W + 1) / 2);

    logic              sync1_q, sync2_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              bit_val;

    assign bit_val  = (cnt_q >= THRESH);
    assign oShift_d = shift_d;

    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (iClr) begin
            cnt_d = '0;
        end else if (iDecide) begin
            cnt_d = '0;
            if (iShift_en) begin
                shift_d = (shift_q << 1) | DATA_W'(bit_val);
            end
        end else if (iVote_en) begin
            cnt_d = cnt_q + CNT_W'(sync2_q);
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            sync1_q <= iMiso;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/spi_adc_multi_sampler.sv
// NCH-lane SPI ADC reader sharing one CS_n/SCLK, with per-bit majority voting and abort/overrun reporting.
// Latency: CS_n falls the cycle after a start; oValid pulses FRAME_BITS*BIT_CYC cycles after CS_n falls.
// No backpressure: starts arriving while busy are dropped and flagged on oOverrun (one cycle later).
//
// Ports: iAcquire_en (rising-edge start), iContinuous (restart from IDLE), iAbort (kill frame),
//        iMISO[c] lane c; oCS_n/oSCLK SPI master outputs (SCLK idles high),
//        oData lane c at [c*DATA_W +: DATA_W], oValid result strobe, oBusy, oOverrun.
module spi_adc_multi_sampler
    import adc_spi_pkg::*;
#(
    parameter int NCH        = 3,
    parameter int DATA_W     = 12,
    parameter int LEAD_BITS  = 3,
    parameter int TRAIL_BITS = 1,
    parameter int HALF_DIV   = 10,
    parameter int QUIET_CYC  = 40
) (
    input  logic                  iClk,
    input  logic                  iRst_n,
    input  logic                  iAcquire_en,
    input  logic                  iContinuous,
    input  logic                  iAbort,
    input  logic [NCH-1:0]        iMISO,
    output logic                  oCS_n,
    output logic                  oSCLK,
    output logic [NCH*DATA_W-1:0] oData,
    output logic                  oValid,
    output logic                  oBusy,
    output logic                  oOverrun
);

    localparam int FRAME_BITS = frame_bits(LEAD_BITS, DATA_W, TRAIL_BITS);
    localparam int BIT_CYC    = bit_cyc(HALF_DIV);
    localparam int PH_W       = cnt_w(BIT_CYC);
    localparam int K_W        = cnt_w(FRAME_BITS);
    localparam int Q_W        = cnt_w(QUIET_CYC + 1);

    localparam logic [PH_W-1:0] PH_LAST    = PH_W'(BIT_CYC - 1);
    localparam logic [PH_W-1:0] PH_HALF    = PH_W'(HALF_DIV);
    localparam logic [PH_W-1:0] PH_VOTE_LO = PH_W'(HALF_DIV + 1);
    localparam logic [PH_W-1:0] PH_VOTE_HI = PH_W'(BIT_CYC - 3);
    localparam logic [K_W-1:0]  K_LAST     = K_W'(FRAME_BITS - 1);
    localparam logic [K_W-1:0]  K_DATA_LO  = K_W'(LEAD_BITS);
    localparam logic [K_W-1:0]  K_DATA_HI  = K_W'(LEAD_BITS + DATA_W - 1);

    // The DONE cycle already holds CS_n high, so after a completed frame QUIET
    // only needs QUIET_CYC-1 more cycles. After an abort the full count applies.
    localparam logic [Q_W-1:0] Q_AFTER_DONE  = Q_W'((QUIET_CYC > 1) ? (QUIET_CYC - 1) : 0);
    localparam logic [Q_W-1:0] Q_AFTER_ABORT = Q_W'(QUIET_CYC);

    logic [1:0]            state_q, state_d;
    logic [PH_W-1:0]       ph_q, ph_d;
    logic [K_W-1:0]        k_q, k_d;
    logic [Q_W-1:0]        quiet_q, quiet_d;
    logic                  cs_n_q, cs_n_d;
    logic                  sclk_q, sclk_d;
    logic                  acq_q, acq_d;
    logic                  valid_q, valid_d;
    logic                  ovr_q, ovr_d;
    logic [NCH*DATA_W-1:0] data_q, data_d;

    logic                  start_edge;
    logic                  frame_start;
    logic                  vote_en;
    logic                  decide;
    logic                  shift_en;
    logic [NCH*DATA_W-1:0] shift_nxt;

    assign start_edge  = iAcquire_en & ~acq_q;
    assign frame_start = (state_q == ST_IDLE) && (start_edge || iContinuous);
    assign vote_en     = (state_q == ST_FRAME) && (ph_q >= PH_VOTE_LO) && (ph_q <= PH_VOTE_HI);
    assign decide      = (state_q == ST_FRAME) && (ph_q == PH_LAST);
    assign shift_en    = (k_q >= K_DATA_LO) && (k_q <= K_DATA_HI);

    for (genvar c = 0; c < NCH; c++) begin : g_lane
        spi_bit_voter #(
            .DATA_W   (DATA_W),
            .HALF_DIV (HALF_DIV)
        ) u_voter (
            .iClk      (iClk),
            .iRst_n    (iRst_n),
            .iMiso     (iMISO[c]),
            .iClr      (frame_start),
            .iVote_en  (vote_en),
            .iDecide   (decide),
            .iShift_en (shift_en),
            .oShift_d  (shift_nxt[c*DATA_W +: DATA_W])
        );
    end

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        k_d     = k_q;
        quiet_d = quiet_q;
        data_d  = data_q;
        valid_d = 1'b0;
        acq_d   = iAcquire_en;
        // Any start edge outside IDLE is dropped, including one coinciding with an abort.
        ovr_d   = start_edge && (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    state_d = ST_FRAME;
                    ph_d    = '0;
                    k_d     = '0;
                end
            end
            ST_FRAME: begin
                if (iAbort) begin
                    state_d = (QUIET_CYC > 0) ? ST_QUIET : ST_IDLE;
                    quiet_d = Q_AFTER_ABORT;
                end else if (ph_q == PH_LAST) begin
                    ph_d = '0;
                    if (k_q == K_LAST) begin
                        state_d = ST_DONE;
                        // shift_nxt includes a bit decided on this very edge,
                        // which matters when there are no trailing bits.
                        data_d  = shift_nxt;
                        valid_d = 1'b1;
                    end else begin
                        k_d = k_q + K_W'(1);
                    end
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            ST_DONE: begin
                state_d = (QUIET_CYC > 1) ? ST_QUIET : ST_IDLE;
                quiet_d = Q_AFTER_DONE;
            end
            ST_QUIET: begin
                if (quiet_q <= Q_W'(1)) begin
                    state_d = ST_IDLE;
                    quiet_d = '0;
                end else begin
                    quiet_d = quiet_q - Q_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // SPI pins are registered from next-state values so they change cleanly on the clock.
        cs_n_d = (state_d != ST_FRAME);
        sclk_d = (state_d != ST_FRAME) || (ph_d < PH_HALF);
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= ST_IDLE;
            ph_q    <= '0;
            k_q     <= '0;
            quiet_q <= '0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b1;
            acq_q   <= 1'b0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            k_q     <= k_d;
            quiet_q <= quiet_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            acq_q   <= acq_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            data_q  <= data_d;
        end
    end

    assign oCS_n    = cs_n_q;
    assign oSCLK    = sclk_q;
    assign oData    = data_q;
    assign oValid   = valid_q;
    assign oBusy    = (state_q != ST_IDLE);
    assign oOverrun = ovr_q;

endmodule

// File: tb/tb_spi_adc_multi_sampler.sv
// Scoreboard bench for spi_adc_multi_sampler: ADC lane models drive MISO from
// CS_n/SCLK, stimulus pushes expected frames, a monitor pops and compares on oValid.
// Default parameters: 16-bit frames of 20 iClk cycles per bit, 40-cycle quiet time.
module tb_spi_adc_multi_sampler;

    localparam int NCH    = 3;
    localparam int DATA_W = 12;
    localparam int FB     = 16;

    logic                  iClk;
    logic                  iRst_n;
    logic                  iAcquire_en;
    logic                  iContinuous;
    logic                  iAbort;
    logic [NCH-1:0]        iMISO;
    logic                  oCS_n;
    logic                  oSCLK;
    logic [NCH*DATA_W-1:0] oData;
    logic                  oValid;
    logic                  oBusy;
    logic                  oOverrun;

    spi_adc_multi_sampler #(
        .NCH(NCH), .DATA_W(DATA_W), .LEAD_BITS(3), .TRAIL_BITS(1),
        .HALF_DIV(10), .QUIET_CYC(40)
    ) dut (
        .iClk(iClk), .iRst_n(iRst_n), .iAcquire_en(iAcquire_en),
        .iContinuous(iContinuous), .iAbort(iAbort), .iMISO(iMISO),
        .oCS_n(oCS_n), .oSCLK(oSCLK), .oData(oData), .oValid(oValid),
        .oBusy(oBusy), .oOverrun(oOverrun)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    int cyc = 0;
    always @(posedge iClk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    logic [NCH*DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0]     adc_val[NCH];
    bit                    noise_en = 1'b0;

    int valid_cnt   = 0;
    int ovr_cnt     = 0;
    int cs_fall_cyc = 0;
    int last_valid  = 0;
    int prev_valid  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [NCH*DATA_W-1:0] pack3(input logic [11:0] c0, input logic [11:0] c1,
                                                    input logic [11:0] c2);
        return {c2, c1, c0};
    endfunction

    task automatic set_vals(input logic [11:0] c0, input logic [11:0] c1, input logic [11:0] c2);
        adc_val[0] = c0;
        adc_val[1] = c1;
        adc_val[2] = c2;
    endtask

    // ADC model: first bit presented when CS_n falls, next bit on each SCLK rise.
    // Frame on the wire: 3 leading zeros, 12 data bits MSB first, 1 trailing zero.
    // Noise inverts lane 0 during bit cycles 12..13, which land on vote samples 14..15.
    initial begin : adc_model
        int idx;
        int cnt;
        logic cs_p;
        logic sclk_p;
        logic [FB-1:0] w;
        logic b;
        idx = 0; cnt = 0; cs_p = 1'b1; sclk_p = 1'b1;
        iMISO = '0;
        forever begin
            @(posedge iClk);
            #1;
            if (oCS_n !== 1'b0) begin
                idx = 0; cnt = 0;
            end else if (cs_p === 1'b1) begin
                idx = 0; cnt = 0;
            end else if (oSCLK === 1'b1 && sclk_p === 1'b0) begin
                idx++; cnt = 0;
            end else begin
                cnt++;
            end
            for (int c = 0; c < NCH; c++) begin
                w = {3'b000, adc_val[c], 1'b0};
                b = (oCS_n === 1'b0 && idx < FB) ? w[FB-1-idx] : 1'b0;
                if (noise_en && c == 0 && (cnt == 12 || cnt == 13)) b = ~b;
                iMISO[c] = b;
            end
            cs_p   = oCS_n;
            sclk_p = oSCLK;
        end
    end

    // Monitor: pops the scoreboard on every oValid and checks data and latency.
    initial begin : monitor
        logic cs_p;
        logic [NCH*DATA_W-1:0] e;
        cs_p = 1'b1;
        forever begin
            @(negedge iClk);
            if (iRst_n !== 1'b1) begin
                cs_p = 1'b1;
            end else begin
                if (cs_p === 1'b1 && oCS_n === 1'b0) cs_fall_cyc = cyc;
                cs_p = oCS_n;
                if (oOverrun === 1'b1) ovr_cnt++;
                if (oValid === 1'b1) begin
                    prev_valid = last_valid;
                    last_valid = cyc;
                    valid_cnt++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_valid", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame_data", 64'(oData), 64'(e));
                        // oValid in the 321st cycle counting the first CS_n-low cycle as 1
                        check("frame_latency", 64'(cyc - cs_fall_cyc), 64'd320);
                    end
                end
            end
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_cs_n"},    64'(oCS_n),    64'd1);
        check({tag, "_sclk"},    64'(oSCLK),    64'd1);
        check({tag, "_data"},    64'(oData),    64'd0);
        check({tag, "_valid"},   64'(oValid),   64'd0);
        check({tag, "_busy"},    64'(oBusy),    64'd0);
        check({tag, "_overrun"}, 64'(oOverrun), 64'd0);
    endtask

    task automatic start_shot();
        @(posedge iClk); #1 iAcquire_en = 1'b1;
        @(posedge iClk); #1 iAcquire_en = 1'b0;
    endtask

    task automatic wait_valid(input int target, input int budget);
        int n;
        n = 0;
        while (valid_cnt < target && n < budget) begin
            @(negedge iClk); #1;
            n++;
        end
        if (valid_cnt < target) check("timeout_valid", 64'd0, 64'd1);
    endtask

    task automatic wait_cs_low(input int budget);
        int n;
        n = 0;
        while (oCS_n !== 1'b0 && n < budget) begin
            @(negedge iClk); #1;
            n++;
        end
        if (oCS_n !== 1'b0) check("timeout_cs_low", 64'd0, 64'd1);
    endtask

    initial begin : stimulus
        int v;
        int o;
        int gap;
        logic [NCH*DATA_W-1:0] old_data;

        iRst_n = 1'b1; iAcquire_en = 1'b0; iContinuous = 1'b0; iAbort = 1'b0;
        set_vals(12'h000, 12'h000, 12'h000);
        #2 iRst_n = 1'b0;
        repeat (3) @(posedge iClk);
        @(negedge iClk);
        check_reset("reset");
        @(posedge iClk); #1 iRst_n = 1'b1;
        repeat (4) @(negedge iClk);
        check_reset("post_reset");

        // 1: single shot
        set_vals(12'hABC, 12'h123, 12'hFFF);
        exp_q.push_back(pack3(12'hABC, 12'h123, 12'hFFF));
        v = valid_cnt;
        start_shot();
        wait_valid(v + 1, 1000);
        repeat (80) @(posedge iClk);

        // 2: two inverted vote samples per bit on lane 0
        set_vals(12'h555, 12'h2AA, 12'h0F0);
        noise_en = 1'b1;
        exp_q.push_back(pack3(12'h555, 12'h2AA, 12'h0F0));
        v = valid_cnt;
        start_shot();
        wait_valid(v + 1, 1000);
        noise_en = 1'b0;
        repeat (80) @(posedge iClk);

        // 3: continuous mode, three frames, deasserted during the third
        set_vals(12'h111, 12'h222, 12'h333);
        repeat (3) exp_q.push_back(pack3(12'h111, 12'h222, 12'h333));
        v = valid_cnt;
        @(posedge iClk); #1 iContinuous = 1'b1;
        wait_valid(v + 1, 1000);
        gap = 0;
        while (oCS_n === 1'b1 && gap < 200) begin
            gap++;
            @(negedge iClk); #1;
        end
        check("cont_cs_high_gap", 64'(gap), 64'd41);
        wait_valid(v + 2, 1000);
        check("cont_period", 64'(last_valid - prev_valid), 64'd361);
        wait_cs_low(200);
        @(posedge iClk); #1 iContinuous = 1'b0;
        wait_valid(v + 3, 1000);
        repeat (500) @(negedge iClk);
        check("cont_frame_count", 64'(valid_cnt - v), 64'd3);

        // 4: second start edge at frame cycle 100
        set_vals(12'h321, 12'h654, 12'h987);
        exp_q.push_back(pack3(12'h321, 12'h654, 12'h987));
        v = valid_cnt; o = ovr_cnt;
        start_shot();
        wait_cs_low(50);
        repeat (100) @(posedge iClk);
        #1 iAcquire_en = 1'b1;
        @(posedge iClk); #1 iAcquire_en = 1'b0;
        wait_valid(v + 1, 1000);
        repeat (100) @(negedge iClk);
        check("overrun_pulses", 64'(ovr_cnt - o), 64'd1);
        check("overrun_valids", 64'(valid_cnt - v), 64'd1);

        // 5: abort at frame cycle 150, with a coincident start edge
        old_data = oData;
        set_vals(12'h0AA, 12'h0BB, 12'h0CC);
        v = valid_cnt; o = ovr_cnt;
        start_shot();
        wait_cs_low(50);
        repeat (150) @(posedge iClk);
        #1 iAbort = 1'b1; iAcquire_en = 1'b1;
        @(posedge iClk); #1 iAbort = 1'b0; iAcquire_en = 1'b0;
        @(negedge iClk);
        check("abort_cs_n", 64'(oCS_n), 64'd1);
        check("abort_sclk", 64'(oSCLK), 64'd1);
        repeat (400) @(negedge iClk);
        check("abort_overrun", 64'(ovr_cnt - o), 64'd1);
        check("abort_no_valid", 64'(valid_cnt - v), 64'd0);
        check("abort_data_kept", 64'(oData), 64'(old_data));

        // 6: reset at frame cycle 200, then a clean shot
        set_vals(12'hFED, 12'hCBA, 12'h987);
        start_shot();
        wait_cs_low(50);
        repeat (200) @(posedge iClk);
        #1 iRst_n = 1'b0;
        @(negedge iClk);
        check_reset("midframe_reset");
        repeat (3) @(posedge iClk);
        #1 iRst_n = 1'b1;
        repeat (5) @(posedge iClk);
        set_vals(12'h456, 12'h789, 12'hDEF);
        exp_q.push_back(pack3(12'h456, 12'h789, 12'hDEF));
        v = valid_cnt;
        start_shot();
        wait_valid(v + 1, 1000);
        repeat (20) @(negedge iClk);

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
